rv_execute: RTL

- Execute stage (Q102H) of the RISC-V 5-stage pipeline. It sits directly downstream of the decode stage and consumes that stage's pc/imm/reg_data Q102H outputs.
- Selects ALU operands with forwarding from Q103H/Q104H, computes the ALU result, and resolves branches and jumps (taken flag plus target to fetch).
- Registers its results into the Q103H pipeline boundary for the memory stage.

---
 rtl/rv_execute_pkg.sv | 39 +++
 rtl/rv_mdu.sv | 63 ++++++
 rtl/rv_execute.sv | 99 +++++++++
 3 files changed

// File: rtl/rv_execute_pkg.sv
// rv_execute_pkg: shared types and helpers for the RISC-V execute stage.
package rv_execute_pkg;

   typedef enum logic [4:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
      ALU_OR, ALU_AND, ALU_LUI_PASS,
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
   } t_alu_op;

   typedef enum logic [2:0] {
      BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
   } t_br_type;

   typedef struct packed {
      logic       valid_Q102H;
      t_alu_op    alu_op_Q102H;
      logic       sel_a_pc_Q102H;
      logic       sel_b_imm_Q102H;
      t_br_type   br_type_Q102H;
      logic       is_jal_Q102H;
      logic       is_jalr_Q102H;
      logic [4:0] reg_src1_Q102H;
      logic [4:0] reg_src2_Q102H;
      logic       ready_Q103H;
   } t_exe_ctrl;

   function automatic logic is_mdu(input t_alu_op op);
      return op >= ALU_MUL;
   endfunction

   // MEM-stage result wins over WB; x0 never forwards
   function automatic logic [31:0] fwd(input logic [4:0] src, rd3, input logic we3, input logic [31:0] d3,
                                       input logic [4:0] rd4, input logic we4, input logic [31:0] d4, rf);
      return (src == 5'd0) ? 32'd0 :
             (we3 && rd3 != 5'd0 && rd3 == src) ? d3 :
             (we4 && rd4 != 5'd0 && rd4 == src) ? d4 : rf;
   endfunction

endpackage

// File: rtl/rv_mdu.sv
// rv_mdu: iterative 32-cycle multiply/divide unit; only built with RV_EXE_MDU_EN.
`ifdef RV_EXE_MDU_EN
module rv_mdu import rv_execute_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  t_alu_op     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ready,
   output logic        busy,
   output logic [31:0] result
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} t_state;
   t_state      state, state_next;
   t_alu_op     op_q;
   logic [31:0] hi, lo, d, ma, mb;
   logic [4:0]  cnt;
   logic        neg_q, neg_r, sa, sb;
   logic [32:0] sum, trial;
   logic [63:0] prod;
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_next;
   always_comb
      state_next = (state == IDLE && start) ? BUSY :
                   (state == BUSY && cnt == 5'd31) ? DONE :
                   (state == DONE && ready) ? IDLE : state;
   always_comb
      busy = (state == IDLE && start) || state == BUSY;
   always_comb begin
      sa    = op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
      sb    = op inside {ALU_MULH, ALU_DIV, ALU_REM};
      ma    = (sa && a[31]) ? -a : a;
      mb    = (sb && b[31]) ? -b : b;
      sum   = {1'b0, hi} + (lo[0] ? {1'b0, d} : 33'd0);
      trial = {hi, lo[31]} - {1'b0, d};
      prod  = neg_q ? -{hi, lo} : {hi, lo};
   end
   // magnitudes in hi:lo, sign restored at the end; quotient by zero stays all-ones
   always_comb
      result = (op_q == ALU_MUL) ? prod[31:0] :
               (op_q < ALU_DIV) ? prod[63:32] :
               (op_q inside {ALU_DIV, ALU_DIVU}) ? ((d == 32'd0) ? 32'hFFFF_FFFF : neg_q ? -lo : lo) :
               neg_r ? -hi : hi;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (state == IDLE && start) begin
         op_q  <= op;
         hi    <= '0;
         lo    <= ma;
         d     <= mb;
         neg_q <= (sa & a[31]) ^ (sb & b[31]);
         neg_r <= sa & a[31];
         cnt   <= '0;
      end else if (state == BUSY) begin
         cnt <= cnt + 5'd1;
         hi  <= (op_q >= ALU_DIV) ? (trial[32] ? {hi[30:0], lo[31]} : trial[31:0]) : sum[32:1];
         lo  <= (op_q >= ALU_DIV) ? {lo[30:0], ~trial[32]} : {sum[0], lo[31:1]};
      end
   end
endmodule
`endif

// File: rtl/rv_execute.sv
// rv_execute: execute stage with forwarding, ALU, branch resolution and Q103H register.
// Optional iterative multiply/divide unit enabled by RV_EXE_MDU_EN.
module rv_execute import rv_execute_pkg::*; #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  t_exe_ctrl   ctrl,
   input  logic [31:0] pc_Q102H,
   input  logic [31:0] imm_Q102H,
   input  logic [31:0] reg_data1_Q102H,
   input  logic [31:0] reg_data2_Q102H,
   input  logic [4:0]  rd_Q103H,
   input  logic        reg_write_en_Q103H,
   input  logic [31:0] fwd_data_Q103H,
   input  logic [4:0]  rd_Q104H,
   input  logic        reg_write_en_Q104H,
   input  logic [31:0] wb_data_Q104H,
   output logic        branch_taken_Q102H,
   output logic [31:0] branch_target_Q102H,
   output logic [31:0] alu_out_Q103H,
   output logic [31:0] store_data_Q103H,
   output logic        valid_Q103H,
   output logic        mdu_busy_Q102H
);
   logic [31:0] rs1, rs2, op_a, op_b, alu, res, pc_plus4_Q103H;
   logic        cond, jump;
   always_comb begin
      rs1  = fwd(ctrl.reg_src1_Q102H, rd_Q103H, reg_write_en_Q103H, fwd_data_Q103H,
                 rd_Q104H, reg_write_en_Q104H, wb_data_Q104H, reg_data1_Q102H);
      rs2  = fwd(ctrl.reg_src2_Q102H, rd_Q103H, reg_write_en_Q103H, fwd_data_Q103H,
                 rd_Q104H, reg_write_en_Q104H, wb_data_Q104H, reg_data2_Q102H);
      op_a = ctrl.sel_a_pc_Q102H ? pc_Q102H : rs1;
      op_b = ctrl.sel_b_imm_Q102H ? imm_Q102H : rs2;
      jump = ctrl.is_jal_Q102H | ctrl.is_jalr_Q102H;
   end
   always_comb begin
      case (ctrl.alu_op_Q102H)
         ALU_ADD:      alu = op_a + op_b;
         ALU_SUB:      alu = op_a - op_b;
         ALU_SLL:      alu = op_a << op_b[4:0];
         ALU_SLT:      alu = {31'd0, $signed(op_a) < $signed(op_b)};
         ALU_SLTU:     alu = {31'd0, op_a < op_b};
         ALU_XOR:      alu = op_a ^ op_b;
         ALU_SRL:      alu = op_a >> op_b[4:0];
         ALU_SRA:      alu = $signed(op_a) >>> op_b[4:0];
         ALU_OR:       alu = op_a | op_b;
         ALU_AND:      alu = op_a & op_b;
         ALU_LUI_PASS: alu = op_b;
         default:      alu = 32'd0;
      endcase
   end
   always_comb begin
      case (ctrl.br_type_Q102H)
         BR_BEQ:  cond = rs1 == rs2;
         BR_BNE:  cond = rs1 != rs2;
         BR_BLT:  cond = $signed(rs1) < $signed(rs2);
         BR_BGE:  cond = $signed(rs1) >= $signed(rs2);
         BR_BLTU: cond = rs1 < rs2;
         BR_BGEU: cond = rs1 >= rs2;
         default: cond = 1'b0;
      endcase
   end
   always_comb begin
      branch_target_Q102H = ctrl.is_jalr_Q102H ? ((rs1 + imm_Q102H) & ~32'h1) : pc_Q102H + imm_Q102H;
      branch_taken_Q102H  = ctrl.valid_Q102H & (jump | cond) & ~mdu_busy_Q102H;
   end
`ifdef RV_EXE_MDU_EN
   logic [31:0] mdu_result;
   rv_mdu u_mdu (
      .clk    (clk),
      .rst    (rst),
      .start  (ctrl.valid_Q102H & is_mdu(ctrl.alu_op_Q102H)),
      .op     (ctrl.alu_op_Q102H),
      .a      (rs1),
      .b      (rs2),
      .ready  (ctrl.ready_Q103H),
      .busy   (mdu_busy_Q102H),
      .result (mdu_result)
   );
   assign res = is_mdu(ctrl.alu_op_Q102H) ? mdu_result : alu;
`else
   assign mdu_busy_Q102H = 1'b0;
   assign res = alu;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out_Q103H    <= '0;
         store_data_Q103H <= '0;
         valid_Q103H      <= 1'b0;
         pc_plus4_Q103H   <= RESET_PC;
      end else if (ctrl.ready_Q103H) begin
         alu_out_Q103H    <= jump ? pc_Q102H + 32'd4 : res;
         store_data_Q103H <= rs2;
         valid_Q103H      <= ctrl.valid_Q102H & ~mdu_busy_Q102H;
         pc_plus4_Q103H   <= pc_Q102H + 32'd4;
      end
   end
endmodule
